// File: rtl/gfx_pkg.sv
// Shared graphics types and helpers for the VGA output end of the pipeline.
//   pal_entry_t : packed RRRGGGBB palette entry
//   rgb_t       : three 8-bit VGA channels
//   expand()    : RRRGGGBB -> 8/8/8 by bit replication
//   RESET_PAL   : power-on colours for codes 0..3 of every palette set
//   CTRL_*      : bit positions inside the palette CTRL register
package gfx_pkg;

    typedef struct packed {
        logic [2:0] r;
        logic [2:0] g;
        logic [1:0] b;
    } pal_entry_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    // Codes 0..3 power up as black, red, green, white (code 0 in the low byte).
    localparam logic [31:0] RESET_PAL = 32'hFF1C_E000;

    localparam int CTRL_DEFER   = 0;
    localparam int CTRL_BLINK   = 1;
    localparam int CTRL_SET_LSB = 2;

    // Power-on value for a colour code; codes above 3 start black.
    function automatic logic [7:0] reset_entry(input int unsigned code);
        case (code)
            0:       return RESET_PAL[7:0];
            1:       return RESET_PAL[15:8];
            2:       return RESET_PAL[23:16];
            3:       return RESET_PAL[31:24];
            default: return 8'h00;
        endcase
    endfunction

    // Replicate the narrow fields so full-scale codes reach 0xFF and zero stays 0x00.
    function automatic rgb_t expand(input pal_entry_t e);
        rgb_t c;
        c.r = {e.r, e.r, e.r[2:1]};
        c.g = {e.g, e.g, e.g[2:1]};
        c.b = {4{e.b}};
        return c;
    endfunction

endpackage

// File: rtl/sync_delay.sv
// Fixed-depth shift register with a per-bit reset value.
//   clk, rst : clock, synchronous active-high reset
//   d_in     : W-bit input sampled every cycle
//   d_out    : d_in delayed by DEPTH cycles (RST_VAL while flushing after reset)
module sync_delay #(
    parameter int             DEPTH   = 2,
    parameter int             W       = 1,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d_in,
    output logic [W-1:0] d_out
);

    logic [W-1:0] stage_q [DEPTH];
    logic [W-1:0] stage_d [DEPTH];

    always_comb begin
        stage_d[0] = d_in;
        for (int i = 1; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    // NOTE: state updates use <= so every stage samples its neighbour's old value on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= RST_VAL;
            end
        end else begin
            stage_q <= stage_d;
        end
    end

    assign d_out = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_palette_stage.sv
// Final graphics stage: colour code -> 8/8/8 VGA through a CPU-writable palette.
//   clk, rst                          : clock, synchronous active-high reset
//   cs_l, we_l, addr, data_in         : CPU bus (active-low select / write)
//   data_out                          : registered read data (shadow entry, border, CTRL)
//   hs_in, vs_in, blank_n_in          : raw timing, aligned with the start of the lookup
//   output_blank_in, code_in          : border flag and colour code, PIPE_LAT cycles later
//   VGA_HS, VGA_VS, VGA_BLANK_N       : timing delayed by PIPE_LAT+1
//   VGA_R, VGA_G, VGA_B               : registered colour, aligned with the timing outputs
// Palette writes go to a shadow copy; with CTRL.defer set they reach the active copy
// only on the delayed vsync falling edge, so a frame never shows a half-updated palette.
module vga_palette_stage
    import gfx_pkg::*;
#(
    parameter int          CODE_W     = 2,
    parameter int          SETS_LOG2  = 2,
    parameter int          PIPE_LAT   = 2,
    parameter logic [15:0] PAL_BASE   = 16'h1400,
    parameter int          BLINK_LOG2 = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cs_l,
    input  logic              we_l,
    input  logic [15:0]       addr,
    input  logic [7:0]        data_in,
    output logic [7:0]        data_out,
    input  logic              hs_in,
    input  logic              vs_in,
    input  logic              blank_n_in,
    input  logic              output_blank_in,
    input  logic [CODE_W-1:0] code_in,
    output logic              VGA_HS,
    output logic              VGA_VS,
    output logic              VGA_BLANK_N,
    output logic [7:0]        VGA_R,
    output logic [7:0]        VGA_G,
    output logic [7:0]        VGA_B
);

    localparam int          IDX_W      = CODE_W + SETS_LOG2;
    localparam int          ENTRIES    = 1 << IDX_W;
    localparam int          CODES      = 1 << CODE_W;
    localparam int          CTRL_W     = SETS_LOG2 + 2;
    localparam int          FRAME_W    = BLINK_LOG2 + 1;
    localparam logic [15:0] OFF_BORDER = 16'(ENTRIES);
    localparam logic [15:0] OFF_CTRL   = 16'(ENTRIES + 1);

    // Bus decode. Addresses below PAL_BASE wrap to large offsets and decode as nothing.
    logic [15:0]      off;
    logic             acc_pal, acc_border, acc_ctrl, wr, rd;
    logic [IDX_W-1:0] bus_idx;

    assign off        = addr - PAL_BASE;
    assign acc_pal    = !cs_l && (off < OFF_BORDER);
    assign acc_border = !cs_l && (off == OFF_BORDER);
    assign acc_ctrl   = !cs_l && (off == OFF_CTRL);
    assign wr         = !we_l;
    assign rd         = we_l;
    assign bus_idx    = off[IDX_W-1:0];

    // Timing delay line: {hs, vs, blank_n} reset to inactive syncs and blanked.
    logic [2:0] timing_dly;
    logic       hs_dly, vs_dly, bn_dly;

    sync_delay #(
        .DEPTH   (PIPE_LAT),
        .W       (3),
        .RST_VAL (3'b110)
    ) u_timing_dly (
        .clk   (clk),
        .rst   (rst),
        .d_in  ({hs_in, vs_in, blank_n_in}),
        .d_out (timing_dly)
    );

    assign {hs_dly, vs_dly, bn_dly} = timing_dly;

    // State
    pal_entry_t         shadow_q [ENTRIES];
    pal_entry_t         shadow_d [ENTRIES];
    pal_entry_t         active_q [ENTRIES];
    pal_entry_t         active_d [ENTRIES];
    pal_entry_t         border_q, border_d;
    logic [CTRL_W-1:0]  ctrl_q, ctrl_d;
    logic               pending_q, pending_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic [7:0]         data_out_q, data_out_d;
    logic               vga_hs_q, vga_hs_d;
    logic               vga_vs_q, vga_vs_d;
    logic               vga_bn_q, vga_bn_d;
    rgb_t               rgb_q, rgb_d;

    // vga_vs_q holds last cycle's delayed vs, so no extra edge-detect flop is needed.
    logic                 vs_fall;
    logic [SETS_LOG2-1:0] eff_set;
    logic [IDX_W-1:0]     pix_idx;

    assign vs_fall = vga_vs_q && !vs_dly;
    assign eff_set = ctrl_q[CTRL_SET_LSB +: SETS_LOG2]
                   ^ (ctrl_q[CTRL_BLINK] ? SETS_LOG2'(frame_q[FRAME_W-1]) : '0);
    assign pix_idx = {eff_set, code_in};

    // NOTE: every _d starts from its _q so no path through this block leaves a latch behind.
    always_comb begin
        shadow_d   = shadow_q;
        active_d   = active_q;
        border_d   = border_q;
        ctrl_d     = ctrl_q;
        pending_d  = pending_q;
        frame_d    = frame_q;
        data_out_d = data_out_q;

        if (vs_fall) begin
            frame_d = frame_q + 1'b1;
            if (pending_q) begin
                active_d  = shadow_q;
                pending_d = 1'b0;
            end
        end

        // Applied after the commit: a same-cycle write still lands in shadow and re-arms pending.
        if (acc_pal && wr) begin
            shadow_d[bus_idx] = pal_entry_t'(data_in);
            if (ctrl_q[CTRL_DEFER]) begin
                pending_d = 1'b1;
            end else begin
                active_d[bus_idx] = pal_entry_t'(data_in);
            end
        end
        if (acc_border && wr) border_d = pal_entry_t'(data_in);
        if (acc_ctrl && wr)   ctrl_d   = data_in[CTRL_W-1:0];

        if (acc_pal && rd)    data_out_d = shadow_q[bus_idx];
        if (acc_border && rd) data_out_d = border_q;
        if (acc_ctrl && rd)   data_out_d = 8'(ctrl_q);

        vga_hs_d = hs_dly;
        vga_vs_d = vs_dly;
        vga_bn_d = bn_dly;
        if (!bn_dly) begin
            rgb_d = '0;
        end else if (output_blank_in) begin
            rgb_d = expand(border_q);
        end else begin
            rgb_d = expand(active_q[pix_idx]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the palette arrays are reset on purpose -- the first frame after reset must show known colours.
            for (int i = 0; i < ENTRIES; i++) begin
                shadow_q[i] <= pal_entry_t'(reset_entry(i % CODES));
                active_q[i] <= pal_entry_t'(reset_entry(i % CODES));
            end
            border_q   <= '0;
            ctrl_q     <= '0;
            pending_q  <= 1'b0;
            frame_q    <= '0;
            data_out_q <= '0;
            vga_hs_q   <= 1'b1;
            vga_vs_q   <= 1'b1;
            vga_bn_q   <= 1'b0;
            rgb_q      <= '0;
        end else begin
            shadow_q   <= shadow_d;
            active_q   <= active_d;
            border_q   <= border_d;
            ctrl_q     <= ctrl_d;
            pending_q  <= pending_d;
            frame_q    <= frame_d;
            data_out_q <= data_out_d;
            vga_hs_q   <= vga_hs_d;
            vga_vs_q   <= vga_vs_d;
            vga_bn_q   <= vga_bn_d;
            rgb_q      <= rgb_d;
        end
    end

    assign data_out    = data_out_q;
    assign VGA_HS      = vga_hs_q;
    assign VGA_VS      = vga_vs_q;
    assign VGA_BLANK_N = vga_bn_q;
    assign VGA_R       = rgb_q.r;
    assign VGA_G       = rgb_q.g;
    assign VGA_B       = rgb_q.b;

endmodule

// File: tb/tb_vga_palette_stage.sv
// Directed bench for vga_palette_stage (defaults, BLINK_LOG2=0 so blink flips every frame).
module tb_vga_palette_stage;

    localparam logic [23:0] BLACK = 24'h000000;
    localparam logic [23:0] RED   = 24'hFF0000;
    localparam logic [23:0] GREEN = 24'h00FF00;
    localparam logic [23:0] BLUE  = 24'h0000FF;

    localparam logic [15:0] A_PAL0   = 16'h1400;
    localparam logic [15:0] A_BORDER = 16'h1410;
    localparam logic [15:0] A_CTRL   = 16'h1411;
    localparam logic [15:0] A_NONE   = 16'h1412;

    logic        clk = 1'b0;
    logic        rst;
    logic        cs_l, we_l;
    logic [15:0] addr;
    logic [7:0]  data_in, data_out;
    logic        hs_in, vs_in, blank_n_in, output_blank_in;
    logic [1:0]  code_in;
    logic        VGA_HS, VGA_VS, VGA_BLANK_N;
    logic [7:0]  VGA_R, VGA_G, VGA_B;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;
    int frames  = 0;
    logic [23:0] exp_rgb;

    vga_palette_stage #(
        .CODE_W     (2),
        .SETS_LOG2  (2),
        .PIPE_LAT   (2),
        .PAL_BASE   (16'h1400),
        .BLINK_LOG2 (0)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .cs_l            (cs_l),
        .we_l            (we_l),
        .addr            (addr),
        .data_in         (data_in),
        .data_out        (data_out),
        .hs_in           (hs_in),
        .vs_in           (vs_in),
        .blank_n_in      (blank_n_in),
        .output_blank_in (output_blank_in),
        .code_in         (code_in),
        .VGA_HS          (VGA_HS),
        .VGA_VS          (VGA_VS),
        .VGA_BLANK_N     (VGA_BLANK_N),
        .VGA_R           (VGA_R),
        .VGA_G           (VGA_G),
        .VGA_B           (VGA_B)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_rgb(input string tag, input logic [23:0] exp);
        check(tag, {8'h00, VGA_R, VGA_G, VGA_B}, {8'h00, exp});
    endtask

    task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
        cs_l = 1'b0; we_l = 1'b0; addr = a; data_in = d;
        tick(1);
        cs_l = 1'b1; we_l = 1'b1;
    endtask

    task automatic cpu_read(input logic [15:0] a);
        cs_l = 1'b0; we_l = 1'b1; addr = a;
        tick(1);
        cs_l = 1'b1;
    endtask

    // One full vsync pulse; the delayed falling edge lands inside the low phase.
    task automatic do_vsync();
        vs_in = 1'b0;
        tick(4);
        vs_in = 1'b1;
        tick(4);
    endtask

    initial begin
        rst = 1'b1; cs_l = 1'b1; we_l = 1'b1; addr = '0; data_in = '0;
        hs_in = 1'b1; vs_in = 1'b1; blank_n_in = 1'b1; output_blank_in = 1'b0; code_in = 2'd1;
        tick(2);
        check("rst_hs",  {31'b0, VGA_HS}, 1);
        check("rst_vs",  {31'b0, VGA_VS}, 1);
        check("rst_bn",  {31'b0, VGA_BLANK_N}, 0);
        check_rgb("rst_rgb", BLACK);
        check("rst_dout", {24'b0, data_out}, 0);

        // Latency: hsync pulse and colour leave together PIPE_LAT+1 cycles later.
        rst = 1'b0; hs_in = 1'b0;
        tick(2);
        check("lat_hs_early", {31'b0, VGA_HS}, 1);
        check("lat_bn_early", {31'b0, VGA_BLANK_N}, 0);
        check_rgb("lat_rgb_early", BLACK);
        tick(1);
        check("lat_hs", {31'b0, VGA_HS}, 0);
        check("lat_vs", {31'b0, VGA_VS}, 1);
        check("lat_bn", {31'b0, VGA_BLANK_N}, 1);
        check_rgb("lat_rgb_red", RED);
        hs_in = 1'b1;

        // Immediate write (defer=0) and readback.
        code_in = 2'd2;
        cpu_write(A_PAL0 + 16'd2, 8'h03);
        tick(1);
        check_rgb("imm_blue", BLUE);
        cpu_read(A_PAL0 + 16'd2);
        check("rd_entry2", {24'b0, data_out}, 32'h03);

        // Deferred write commits only at the delayed vsync falling edge.
        cpu_write(A_CTRL, 8'h01);
        code_in = 2'd0;
        cpu_write(A_PAL0, 8'hE0);
        tick(1);
        check_rgb("defer_hold", BLACK);
        cpu_read(A_PAL0);
        check("rd_shadow0", {24'b0, data_out}, 32'hE0);
        vs_in = 1'b0;
        tick(3);
        check("commit_vs", {31'b0, VGA_VS}, 0);
        check_rgb("commit_edge", BLACK);
        tick(1);
        check_rgb("commit_red", RED);
        frames++;
        vs_in = 1'b1;
        tick(4);

        // Write landing in the commit cycle: old shadow commits, new value waits a frame.
        cpu_write(A_PAL0, 8'h1C);
        tick(1);
        check_rgb("pend_hold", RED);
        vs_in = 1'b0;
        tick(2);
        cpu_write(A_PAL0, 8'h03);
        tick(1);
        check_rgb("race_old", GREEN);
        frames++;
        vs_in = 1'b1;
        tick(4);
        check_rgb("race_wait", GREEN);
        do_vsync();
        frames++;
        check_rgb("race_new", BLUE);

        // Clearing defer while pending does not flush; the next vsync does.
        cpu_write(A_PAL0, 8'hE0);
        cpu_write(A_CTRL, 8'h00);
        tick(1);
        check_rgb("noflush", BLUE);
        do_vsync();
        frames++;
        check_rgb("flush_vsync", RED);

        // Border colour, and blanking overriding everything.
        output_blank_in = 1'b1;
        cpu_write(A_BORDER, 8'h1C);
        tick(1);
        check_rgb("border_green", GREEN);
        blank_n_in = 1'b0;
        tick(3);
        check_rgb("blank_black", BLACK);
        check("blank_bn", {31'b0, VGA_BLANK_N}, 0);
        blank_n_in = 1'b1; output_blank_in = 1'b0;
        tick(3);
        check_rgb("unblank", RED);

        // Blink: set 0 code 1 is red, set 1 code 1 is green; LSB of set follows frame parity.
        code_in = 2'd1;
        cpu_write(A_PAL0 + 16'd5, 8'h1C);
        cpu_write(A_CTRL, 8'h02);
        tick(1);
        exp_rgb = frames[0] ? GREEN : RED;
        check_rgb("blink_a", exp_rgb);
        do_vsync();
        frames++;
        exp_rgb = frames[0] ? GREEN : RED;
        check_rgb("blink_b", exp_rgb);
        do_vsync();
        frames++;
        exp_rgb = frames[0] ? GREEN : RED;
        check_rgb("blink_c", exp_rgb);

        // Register readback and unmapped addresses.
        cpu_read(A_CTRL);
        check("rd_ctrl", {24'b0, data_out}, 32'h02);
        cpu_read(A_NONE);
        check("rd_none_hold", {24'b0, data_out}, 32'h02);
        cpu_write(A_NONE, 8'hAA);
        cpu_read(A_BORDER);
        check("rd_border", {24'b0, data_out}, 32'h1C);
        cpu_read(A_PAL0 + 16'd5);
        check("rd_set1_e1", {24'b0, data_out}, 32'h1C);

        // Reset mid-frame with a deferred write outstanding.
        cpu_write(A_CTRL, 8'h01);
        cpu_write(A_PAL0 + 16'd1, 8'h03);
        hs_in = 1'b0;
        rst = 1'b1;
        tick(1);
        check("mid_rst_hs", {31'b0, VGA_HS}, 1);
        check("mid_rst_vs", {31'b0, VGA_VS}, 1);
        check("mid_rst_bn", {31'b0, VGA_BLANK_N}, 0);
        check_rgb("mid_rst_rgb", BLACK);
        check("mid_rst_dout", {24'b0, data_out}, 0);
        rst = 1'b0; hs_in = 1'b1;
        tick(3);
        check_rgb("post_rst_red", RED);
        do_vsync();
        check_rgb("post_rst_nocommit", RED);
        cpu_read(A_PAL0 + 16'd1);
        check("post_rst_shadow", {24'b0, data_out}, 32'hE0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/vga_palette_stage.md
Name: vga_palette_stage

Overview:
- Parametrised successor to the fixed 2-bit colour-code→RGB mapping at the end of the graphics pipeline.
- Converts pixel colour codes to 8-bit VGA channels through a CPU-writable palette, and delays VGA sync/blank to match the upstream lookup latency.
- Double-buffers palette writes so they commit only at vertical sync, avoiding mid-frame tearing.
- Adds a border colour, selectable palette sets and frame-based blink.

Parameters:
- CODE_W, 2: colour-code width; 2^CODE_W entries per set.
- SETS_LOG2, 2: log2 of palette set count; ENTRIES = 2^(CODE_W+SETS_LOG2).
- PIPE_LAT, 2: cycles from sync/row/col to code_in arriving (tile/sprite lookup depth).
- PAL_BASE, 16'h1400: CPU base address of the palette window.
- BLINK_LOG2, 4: blink toggles every 2^BLINK_LOG2 frames.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- cs_l  in  1  CPU chip select, active low.
- we_l  in  1  CPU write enable, active low.
- addr  in  16  CPU address.
- data_in  in  8  CPU write data.
- data_out  out  8  CPU read data: shadow entry / register.
- hs_in, vs_in, blank_n_in  in  1 each  raw VGA timing, active low syncs.
- output_blank_in  in  1  border/off-playfield flag, aligned with code_in.
- code_in  in  CODE_W  pixel colour code, valid PIPE_LAT cycles after matching sync.
- VGA_HS, VGA_VS, VGA_BLANK_N  out  1 each  delayed timing.
- VGA_R, VGA_G, VGA_B  out  8 each  registered colour.

Behaviour:
- Address map, decoded when cs_l=0:
  - PAL_BASE+i, i<ENTRIES: palette entry {set,code}, format RRRGGGBB.
  - PAL_BASE+ENTRIES: border register.
  - PAL_BASE+ENTRIES+1: CTRL register. Bit0 = defer (1: commit at vsync). Bit1 = blink enable. Bits[SETS_LOG2+1:2] = active set.
  - Other addresses: writes ignored; data_out holds its previous value.
- Reads: data_out is registered, valid the cycle after the access. Returns the shadow entry, border, or CTRL.
- Writes:
  - Always update the shadow copy.
  - defer=0: also update the active copy in the same cycle.
  - defer=1: set pending.
  - Border and CTRL writes take effect immediately.
- Commit:
  - Triggered when delayed vs_in falls (1→0) with pending=1.
  - Whole shadow array is copied to active in one cycle; pending clears.
  - A CPU write in the commit cycle: the copy uses pre-write shadow, the write lands in shadow, and pending stays 1.
  - Clearing defer while pending does not flush; the next vsync falling edge commits.
- Blink:
  - Frame counter (BLINK_LOG2+1 bits) increments on each delayed vs_in falling edge, wrapping.
  - Effective set = active set XOR {.., counter MSB} (LSB flips) when blink=1.
- Timing path:
  - hs/vs/blank_n pass through a PIPE_LAT-deep shift register plus the output register. Total latency PIPE_LAT+1.
  - RGB register is loaded from the entry {eff_set, code_in}, or from border if output_blank_in=1, or 0 if the delayed blank_n=0.
  - Result: colour and sync leave together, PIPE_LAT+1 cycles after the sync input.
- Expansion:
  - R = {r2,r1,r0,r2,r1,r0,r2,r1}
  - G = same pattern from the green bits.
  - B = {b1,b0} repeated 4 times.
- Reset (rst=1 at clk edge):
  - All sets reset to {0x00,0xE0,0x1C,0xFF} per 4 codes. For CODE_W>2, code k>3 resets to 0x00.
  - Border 0x00; CTRL 0; pending 0; frame counter 0.
  - Delay line: HS=1, VS=1, BLANK_N=0. RGB=0; data_out=0.
  - Reset mid-frame discards any pending commit.

Decomposition:
- Shared package gfx_pkg:
  - pal_entry_t (RRRGGGBB struct).
  - rgb_t (three 8-bit channels).
  - expand function (RRRGGGBB → rgb_t).
  - Reset palette constant.
  - CTRL bit positions.
- One sub-module, sync_delay #(DEPTH, W): shift register with reset value per bit, used for the timing path and reusable elsewhere.

Test Plan:
- Reset, code_in=1, blank_n=1, output_blank=0 → at PIPE_LAT+1 cycles: R=FF, G=00, B=00, HS/VS delayed identically.
- defer=0, write 0x03 to PAL_BASE+2, code 2 → B=FF, R=G=00 on the next pixel. Readback of PAL_BASE+2 = 0x03 one cycle after the read.
- defer=1, write 0xE0 to PAL_BASE+0 mid-frame → code 0 stays black until the delayed vs falling edge, then R=FF. Pending clears.
- Write in the exact commit cycle with defer=1 → the old value commits, the new value appears only after the next vsync.
- output_blank_in=1, border=0x1C → G=FF. blank_n=0 → RGB=0 regardless.
- blink=1, BLINK_LOG2=0, set 1 entry 1=0x1C → code 1 alternates red/green on successive frames. Assert rst mid-frame → outputs reach reset values the next cycle.
